// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - iterative ALU execution unit with valid/ready handshakes
//
// Ports:
//   clk, rst_n           rising-edge clock, synchronous active-low reset
//   in_valid, in_ready   operation handshake (in_ready high only in IDLE)
//   alu_op, op_a, op_b   operation code and unsigned operands, sampled at accept
//   out_valid, out_ready result handshake (out_valid high only in DONE)
//   result, result_hi    low word / quotient, high word / remainder
//   carry, zero          ADD carry or SUB borrow; low result word is zero
//   div_zero             DIV issued with op_b == 0
module alu_exec #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             carry,
    output logic             zero,
    output logic             div_zero
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_NOT = 3'b111;

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        DIV_BUSY = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t state, state_nx;

    logic [CW-1:0]        cnt;
    logic                 last_step;

    // Shift-add multiplier state
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_nx;
    logic [WIDTH-1:0]     mplier;

    // Restoring divider state; quo starts as the dividend and is shifted
    // out MSB-first while quotient bits shift in at the bottom.
    logic [WIDTH-1:0]     rem;
    logic [WIDTH-1:0]     rem_nx;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH:0]       rem_diff;
    logic [WIDTH-1:0]     quo;
    logic [WIDTH-1:0]     quo_nx;
    logic [WIDTH-1:0]     divisor;

    // Single-cycle op results
    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       diff;
    logic [WIDTH-1:0]     sc_res;
    logic                 sc_carry;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign last_step = (cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (alu_op == OP_MUL) begin
                        state_nx = MUL_BUSY;
                    end else if (alu_op == OP_DIV && op_b != '0) begin
                        state_nx = DIV_BUSY;
                    end else begin
                        state_nx = DONE;
                    end
                end
            end
            MUL_BUSY: if (last_step) state_nx = DONE;
            DIV_BUSY: if (last_step) state_nx = DONE;
            DONE:     if (out_ready) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_comb begin
        acc_nx   = mplier[0] ? (acc + mcand) : acc;

        // Remainder is always < divisor, so the shifted value fits WIDTH+1
        // bits and bit WIDTH of the difference is a clean borrow flag.
        rem_sh   = {rem, quo[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, divisor};
        if (!rem_diff[WIDTH]) begin
            rem_nx = rem_diff[WIDTH-1:0];
            quo_nx = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_nx = rem_sh[WIDTH-1:0];
            quo_nx = {quo[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        sum      = {1'b0, op_a} + {1'b0, op_b};
        diff     = {1'b0, op_a} - {1'b0, op_b};
        sc_res   = sum[WIDTH-1:0];
        sc_carry = sum[WIDTH];
        case (alu_op)
            OP_SUB: begin
                sc_res   = diff[WIDTH-1:0];
                sc_carry = diff[WIDTH];
            end
            OP_AND: begin
                sc_res   = op_a & op_b;
                sc_carry = 1'b0;
            end
            OP_OR: begin
                sc_res   = op_a | op_b;
                sc_carry = 1'b0;
            end
            OP_XOR: begin
                sc_res   = op_a ^ op_b;
                sc_carry = 1'b0;
            end
            OP_NOT: begin
                sc_res   = ~op_a;
                sc_carry = 1'b0;
            end
            OP_ADD: begin
                sc_res   = sum[WIDTH-1:0];
                sc_carry = sum[WIDTH];
            end
            default: begin
                sc_res   = sum[WIDTH-1:0];
                sc_carry = sum[WIDTH];
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            mcand     <= '0;
            acc       <= '0;
            mplier    <= '0;
            rem       <= '0;
            quo       <= '0;
            divisor   <= '0;
            result    <= '0;
            result_hi <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (alu_op == OP_MUL) begin
                            mcand  <= {{WIDTH{1'b0}}, op_a};
                            mplier <= op_b;
                            acc    <= '0;
                            cnt    <= CW'(WIDTH);
                        end else if (alu_op == OP_DIV && op_b != '0) begin
                            rem     <= '0;
                            quo     <= op_a;
                            divisor <= op_b;
                            cnt     <= CW'(WIDTH);
                        end else if (alu_op == OP_DIV) begin
                            result    <= '1;
                            result_hi <= op_a;
                            carry     <= 1'b0;
                            zero      <= 1'b0;
                            div_zero  <= 1'b1;
                        end else begin
                            result    <= sc_res;
                            result_hi <= '0;
                            carry     <= sc_carry;
                            zero      <= (sc_res == '0);
                            div_zero  <= 1'b0;
                        end
                    end
                end
                MUL_BUSY: begin
                    acc    <= acc_nx;
                    mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
                    mplier <= {1'b0, mplier[WIDTH-1:1]};
                    cnt    <= cnt - CW'(1);
                    if (last_step) begin
                        result    <= acc_nx[WIDTH-1:0];
                        result_hi <= acc_nx[2*WIDTH-1:WIDTH];
                        carry     <= 1'b0;
                        zero      <= (acc_nx[WIDTH-1:0] == '0);
                        div_zero  <= 1'b0;
                    end
                end
                DIV_BUSY: begin
                    rem <= rem_nx;
                    quo <= quo_nx;
                    cnt <= cnt - CW'(1);
                    if (last_step) begin
                        result    <= quo_nx;
                        result_hi <= rem_nx;
                        carry     <= 1'b0;
                        zero      <= (quo_nx == '0);
                        div_zero  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// tb/tb_alu_exec.sv - scoreboard testbench for alu_exec
module tb_alu_exec;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    alu_op;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic [W-1:0]  result_hi;
    logic          carry;
    logic          zero;
    logic          div_zero;

    alu_exec #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .carry     (carry),
        .zero      (zero),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         cy;
        logic         zr;
        logic         dz;
        int           first_edge;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    bit   active = 0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Reference model: plain arithmetic on integers.
    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        longint ua, ub, p;
        ua = a;
        ub = b;
        e.hi = '0;
        e.cy = 1'b0;
        e.dz = 1'b0;
        e.first_edge = 0;
        case (op)
            3'd0: begin p = ua + ub;       e.res = W'(p); e.cy = (p > 65535); end
            3'd1: begin p = ua - ub;       e.res = W'(p); e.cy = (ua < ub);   end
            3'd2: begin p = ua * ub;       e.res = W'(p); e.hi = W'(p / 65536); e.first_edge = W; end
            3'd3: begin
                if (ub == 0) begin
                    e.res = 16'hFFFF;
                    e.hi  = a;
                    e.dz  = 1'b1;
                end else begin
                    e.res = W'(ua / ub);
                    e.hi  = W'(ua % ub);
                    e.first_edge = W;
                end
            end
            3'd4: e.res = a & b;
            3'd5: e.res = a | b;
            3'd6: e.res = a ^ b;
            default: e.res = ~a;
        endcase
        e.zr = (e.res == 0);
        return e;
    endfunction

    // Monitor: pops a new expectation on each fresh out_valid and checks
    // every cycle that out_valid stays high (stability under backpressure).
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            active = 0;
        end else if (out_valid) begin
            if (!active) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    cur = sb.pop_front();
                    active = 1;
                    chk("latency_edge", cyc, cur.first_edge);
                end
            end
            if (active) begin
                chk("result",    result,    cur.res);
                chk("result_hi", result_hi, cur.hi);
                chk("carry",     carry,     cur.cy);
                chk("zero",      zero,      cur.zr);
                chk("div_zero",  div_zero,  cur.dz);
            end
        end else begin
            active = 0;
        end
    end

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit scramble);
        exp_t e;
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        alu_op   = op;
        op_a     = a;
        op_b     = b;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
        e = model(op, a, b);
        e.first_edge = e.first_edge + cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        if (scramble) begin
            alu_op = 3'($urandom);
            op_a   = W'($urandom);
            op_b   = W'($urandom);
        end
    endtask

    task automatic complete(input int stall);
        int n;
        n = 0;
        while (!out_valid && n < 60) begin
            chk("busy_in_ready", in_ready, 0);
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            chk("out_valid_timeout", 32'd0, 32'd1);
        end else begin
            for (int i = 0; i < stall; i++) begin
                chk("stall_in_ready", in_ready, 0);
                @(negedge clk);
                chk("stall_out_valid", out_valid, 1);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            chk("post_out_valid", out_valid, 0);
            chk("post_in_ready",  in_ready,  1);
        end
    endtask

    task automatic run(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int stall, input bit scramble);
        issue(op, a, b, scramble);
        complete(stall);
    endtask

    initial begin
        logic [2:0]   rop;
        logic [W-1:0] ra, rb;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_op    = 3'd0;
        op_a      = '0;
        op_b      = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result",    result,    0);
        chk("rst_result_hi", result_hi, 0);
        chk("rst_carry",     carry,     0);
        chk("rst_zero",      zero,      0);
        chk("rst_div_zero",  div_zero,  0);
        rst_n = 1'b1;

        run(3'd0, 16'hFFFF, 16'h0001, 0, 0);
        run(3'd2, 16'h1234, 16'h0100, 0, 0);
        run(3'd3, 16'd100,  16'd7,    0, 0);
        run(3'd3, 16'h0055, 16'h0000, 0, 0);
        run(3'd1, 16'h0003, 16'h0005, 5, 0);

        // Reset in the middle of a multiply: no result may appear for it.
        issue(3'd2, 16'h00FF, 16'h00FF, 0);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready",  in_ready,  1);
        chk("midrst_result",    result,    0);
        chk("midrst_result_hi", result_hi, 0);
        rst_n = 1'b1;
        sb.delete();

        run(3'd6, 16'h0F0F, 16'h00FF, 0, 0);
        run(3'd3, 16'h0064, 16'h000A, 0, 1);
        run(3'd2, 16'hFFFF, 16'hFFFF, 1, 1);
        run(3'd7, 16'h0000, 16'h1234, 0, 0);

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom);
            ra  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : W'($urandom);
            rb  = ($urandom_range(0, 5) == 0) ? 16'h0000 : W'($urandom);
            if ($urandom_range(0, 3) == 0) rb = W'($urandom_range(1, 15));
            run(rop, ra, rb, $urandom_range(0, 2), 1'($urandom));
        end

        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Execution unit that consumes the 3-bit `alu_op` code produced by the ALU control decoder and computes the result on two operands.
- Logic and add/sub ops finish in one cycle.
- MUL (shift-add) and DIV (restoring) are iterative multi-cycle ops.
- Valid/ready handshakes on both the input and output sides, so the datapath can stall on either end.

Parameters:
- WIDTH, 16, operand and result word width in bits; must be >= 2.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operands and op are valid this cycle.
- in_ready  output  1  unit can accept a new operation.
- alu_op  input  3  operation code: ADD=000, SUB=001, MUL=010, DIV=011, AND=100, OR=101, XOR=110, NOT=111.
- op_a  input  WIDTH  operand A, unsigned.
- op_b  input  WIDTH  operand B, unsigned.
- out_valid  output  1  result outputs hold a valid result.
- out_ready  input  1  consumer takes the result this cycle.
- result  output  WIDTH  primary result: low word for MUL, quotient for DIV.
- result_hi  output  WIDTH  MUL high word; DIV remainder; 0 for all other ops.
- carry  output  1  ADD carry-out; SUB borrow (op_a < op_b); 0 otherwise.
- zero  output  1  result == 0 (low word only).
- div_zero  output  1  DIV issued with op_b == 0.

Behaviour:
- Reset: rst_n sampled low at a rising edge forces
  - state = IDLE, in_ready = 1, out_valid = 0;
  - result, result_hi, carry, zero, div_zero = 0;
  - iteration counter and internal shift registers = 0.
  - Reset aborts any in-flight MUL/DIV; no result is produced for it.
- FSM states: IDLE, MUL_BUSY, DIV_BUSY, DONE. in_ready = (state == IDLE), driven combinationally from state.
- Accept: happens on an edge where in_valid && in_ready. Inputs are sampled only at the accept edge; later changes on op_a, op_b and alu_op are ignored.
- Single-cycle ops (ADD, SUB, AND, OR, XOR, NOT):
  - Result is registered at the accept edge, then IDLE -> DONE.
  - out_valid is high in the cycle after the accept cycle (latency 1).
- ADD: result = (op_a + op_b) mod 2^WIDTH; carry = bit WIDTH of the sum.
- SUB: result = (op_a - op_b) mod 2^WIDTH; carry = 1 iff op_a < op_b.
- NOT: result = ~op_a; op_b is ignored.
- MUL:
  - At the accept edge, load multiplicand, multiplier, a 2*WIDTH accumulator, and counter = WIDTH. IDLE -> MUL_BUSY.
  - Each edge in MUL_BUSY performs one shift-add step and decrements the counter.
  - The edge that completes step WIDTH writes {result_hi, result} = op_a * op_b and moves to DONE.
  - out_valid is high WIDTH+1 cycles after the accept cycle.
- DIV (unsigned restoring):
  - Same load/iteration timing as MUL, via DIV_BUSY.
  - Final outputs: result = op_a / op_b, result_hi = op_a % op_b.
- DIV by zero:
  - Detected at the accept edge; no iteration.
  - Goes directly IDLE -> DONE with result = all ones, result_hi = op_a, div_zero = 1 (latency 1).
  - div_zero = 0 for every other completed op.
- zero and carry are computed from the final values and registered together with result.
- DONE state:
  - out_valid = 1; all result outputs are held stable until an edge with out_ready = 1, then DONE -> IDLE.
  - Outputs keep their last values after leaving DONE; out_valid drops to 0.
  - No new accept is possible in the same edge that DONE is exited (in_ready is 0 in DONE).
  - Minimum issue interval is therefore 2 cycles for single-cycle ops.
- Illegal/X alu_op cannot occur (3-bit code is full). The case default behaves as ADD.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE.

Test Plan:
- Reset, then ADD: op_a=0xFFFF, op_b=0x0001 -> in the next cycle out_valid=1, result=0x0000, carry=1, zero=1, result_hi=0x0000.
- MUL: op_a=0x1234, op_b=0x0100 -> in_ready=0 during busy; out_valid rises exactly 17 cycles after the accept cycle with result_hi=0x0012, result=0x3400, zero=0.
- DIV: 100 / 7 -> after 17 cycles result=0x000E, result_hi=0x0002, div_zero=0. Then DIV 0x0055 / 0 -> next cycle result=0xFFFF, result_hi=0x0055, div_zero=1.
- Backpressure: SUB 0x0003 - 0x0005, out_ready held low for 5 cycles -> result=0xFFFE, carry=1, held stable; in_ready=0 throughout. out_ready=1 for one edge -> out_valid=0, in_ready=1 in the next cycle.
- Reset mid-op: start MUL 0x00FF * 0x00FF, assert rst_n=0 at busy cycle 8 -> after that edge out_valid=0, in_ready=1, result=0, result_hi=0. Then a fresh XOR 0x0F0F ^ 0x00FF gives result=0x0FF0 in the next cycle.
- Input change after accept: issue DIV 0x0064 / 0x000A, then drive op_a/op_b/alu_op to random values while busy -> result=0x000A, result_hi=0x0000 (values sampled at the accept edge are used).
